// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Purpose  : Pipelined immediate extension (zero/sign/upper/branch) behind a
//            valid/ready handshake with a 2-entry skid buffer and tag sideband.
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
   parameter int IN_WIDTH    = 16,
   parameter int OUT_WIDTH   = 32,
   parameter int BR_SHIFT    = 2,
   parameter int TAG_WIDTH   = 5,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IN_WIDTH-1:0]    in_imm,
   input  logic [1:0]             in_mode,
   input  logic [TAG_WIDTH-1:0]   in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_WIDTH-1:0]   out_data,
   output logic [TAG_WIDTH-1:0]   out_tag,
   output logic [COUNT_WIDTH-1:0] xfer_count
);

   localparam logic [1:0] c_st_empty = 2'd0;
   localparam logic [1:0] c_st_one   = 2'd1;
   localparam logic [1:0] c_st_full  = 2'd2;

   localparam logic [1:0] c_mode_zero   = 2'd0;
   localparam logic [1:0] c_mode_sign   = 2'd1;
   localparam logic [1:0] c_mode_upper  = 2'd2;

   logic [1:0]             r_state;
   logic [1:0]             w_next_state;
   logic                   r_in_ready;
   logic [OUT_WIDTH-1:0]   r_head_data;
   logic [TAG_WIDTH-1:0]   r_head_tag;
   logic [OUT_WIDTH-1:0]   r_skid_data;
   logic [TAG_WIDTH-1:0]   r_skid_tag;
   logic [COUNT_WIDTH-1:0] r_count;

   logic                   w_accept;
   logic                   w_consume;
   logic                   w_load_head_ext;
   logic                   w_load_head_skid;
   logic                   w_load_skid;

   logic [OUT_WIDTH-1:0]   w_zext;
   logic [OUT_WIDTH-1:0]   w_sext;
   logic [OUT_WIDTH-1:0]   w_upper;
   logic [OUT_WIDTH-1:0]   w_branch;
   logic [OUT_WIDTH-1:0]   w_ext;

   // ------------------------------------------------------------------------
   // Extension arithmetic
   // ------------------------------------------------------------------------
   generate
      if (OUT_WIDTH > IN_WIDTH) begin : g_wide
         assign w_zext  = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, in_imm};
         assign w_sext  = {{(OUT_WIDTH-IN_WIDTH){in_imm[IN_WIDTH-1]}}, in_imm};
         assign w_upper = {in_imm, {(OUT_WIDTH-IN_WIDTH){1'b0}}};
      end else begin : g_equal
         assign w_zext  = in_imm;
         assign w_sext  = in_imm;
         assign w_upper = in_imm;
      end
   endgenerate

   assign w_branch = w_sext << BR_SHIFT;

   always_comb begin
      w_ext = w_branch;
      case (in_mode)
         c_mode_zero:  w_ext = w_zext;
         c_mode_sign:  w_ext = w_sext;
         c_mode_upper: w_ext = w_upper;
         default:      w_ext = w_branch;
      endcase
   end

   assign w_accept  = in_valid && r_in_ready;
   assign w_consume = out_valid && out_ready;

   // ------------------------------------------------------------------------
   // State machine: register / next-state / outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= c_st_empty;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_in_ready <= (w_next_state != c_st_full);
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_empty: if (w_accept) w_next_state = c_st_one;
         c_st_one: begin
            if (w_accept && !w_consume)      w_next_state = c_st_full;
            else if (!w_accept && w_consume) w_next_state = c_st_empty;
         end
         c_st_full:  if (w_consume) w_next_state = c_st_one;
         default:    w_next_state = c_st_empty;
      endcase
   end

   always_comb begin
      out_valid        = (r_state != c_st_empty);
      w_load_head_ext  = 1'b0;
      w_load_head_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         c_st_empty: w_load_head_ext = w_accept;
         c_st_one: begin
            w_load_head_ext = w_accept && w_consume;
            w_load_skid     = w_accept && !w_consume;
         end
         c_st_full:  w_load_head_skid = w_consume;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Storage and transfer counter; data only moves on accept/consume so
   // unqualified input values never reach the outputs.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head_data <= '0;
         r_head_tag  <= '0;
         r_skid_data <= '0;
         r_skid_tag  <= '0;
         r_count     <= '0;
      end else begin
         if (w_load_head_ext) begin
            r_head_data <= w_ext;
            r_head_tag  <= in_tag;
         end else if (w_load_head_skid) begin
            r_head_data <= r_skid_data;
            r_head_tag  <= r_skid_tag;
         end
         if (w_load_skid) begin
            r_skid_data <= w_ext;
            r_skid_tag  <= in_tag;
         end
         if (w_accept) r_count <= r_count + COUNT_WIDTH'(1);
      end
   end

   assign in_ready   = r_in_ready;
   assign out_data   = r_head_data;
   assign out_tag    = r_head_tag;
   assign xfer_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Purpose  : Self-checking bench for imm_extend_pipe against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_imm;
   logic [1:0]    in_mode;
   logic [4:0]    in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic [4:0]    out_tag;
   logic [CW-1:0] xfer_count;

   imm_extend_pipe #(
      .IN_WIDTH(16), .OUT_WIDTH(32), .BR_SHIFT(2), .TAG_WIDTH(5), .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
      .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .xfer_count(xfer_count)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [36:0] q[$];
   logic        rdy_exp  = 1'b0;
   int unsigned cnt_exp  = 0;

   // Reference extension from plain integer arithmetic
   function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
      longint s;
      longint r;
      s = imm[15] ? longint'(imm) - 65536 : longint'(imm);
      case (mode)
         2'd0:    r = longint'(imm);
         2'd1:    r = s;
         2'd2:    r = longint'(imm) * 65536;
         default: r = s * 4;
      endcase
      return r[31:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [36:0] h;
      chk("in_ready", 32'(in_ready), 32'(rdy_exp));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         h = q[0];
         chk("out_data", out_data, h[31:0]);
         chk("out_tag", 32'(out_tag), 32'(h[36:32]));
      end
      chk("xfer_count", 32'(xfer_count), cnt_exp % 16);
   endtask

   // One clock: drive at negedge, update model at posedge, check at next negedge
   task automatic step(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [4:0] tag, input logic ordy);
      logic acc;
      logic con;
      in_valid  = v;
      in_imm    = imm;
      in_mode   = mode;
      in_tag    = tag;
      out_ready = ordy;
      acc = v && rdy_exp;
      con = ordy && (q.size() > 0);
      @(posedge clk);
      if (con) void'(q.pop_front());
      if (acc) begin
         q.push_back({tag, ref_ext(imm, mode)});
         cnt_exp++;
      end
      rdy_exp = (q.size() < 2);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 16'hxxxx, 2'bxx, 5'bxxxxx, ordy);
   endtask

   initial begin
      logic [31:0] exp4 [4];
      exp4[0] = 32'h00008005; exp4[1] = 32'hFFFF8005;
      exp4[2] = 32'h80050000; exp4[3] = 32'hFFFE0014;

      reset = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_count", 32'(xfer_count), 32'd0);
      reset = 1'b0;
      idle(1'b1);

      // Four modes on 0x8005, each visible one cycle after accept
      for (int m = 0; m < 4; m++) begin
         step(1'b1, 16'h8005, 2'(m), 5'(m + 1), 1'b1);
         chk("mode_const", out_data, exp4[m]);
         chk("mode_tag", 32'(out_tag), 32'(m + 1));
      end
      chk("count4", 32'(xfer_count), 32'd4);
      idle(1'b1);

      step(1'b1, 16'hFFFF, 2'd3, 5'd7, 1'b1);
      chk("branch_neg1", out_data, 32'hFFFFFFFC);
      step(1'b1, 16'h7FFF, 2'd1, 5'd8, 1'b1);
      chk("sign_pos", out_data, 32'h00007FFF);
      idle(1'b1);

      // Backpressure into FULL, then drain in order
      step(1'b1, 16'h0001, 2'd0, 5'd9, 1'b0);
      step(1'b1, 16'h0002, 2'd0, 5'd10, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_head", out_data, 32'h00000001);
      idle(1'b0);
      step(1'b1, 16'h0003, 2'd0, 5'd11, 1'b1);
      chk("bp_second", out_data, 32'h00000002);
      idle(1'b1);
      chk("bp_ready_back", 32'(in_ready), 32'd1);
      idle(1'b1);

      // Streaming: one result per cycle, never FULL
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 16'($urandom), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'b1);
         chk("stream_valid", 32'(out_valid), 32'd1);
      end
      idle(1'b1);

      // Randomised handshake traffic
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      idle(1'b1);
      idle(1'b1);

      // Asynchronous reset while FULL
      step(1'b1, 16'h1234, 2'd1, 5'd1, 1'b0);
      step(1'b1, 16'h5678, 2'd2, 5'd2, 1'b0);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      chk("arst_count", 32'(xfer_count), 32'd0);
      chk("arst_out_data", out_data, 32'd0);
      q.delete();
      cnt_exp = 0;
      rdy_exp = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      idle(1'b1);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      idle(1'b1);

      // Counter wrap at 4 bits: 17 accepts leave 1
      for (int i = 0; i < 17; i++)
         step(1'b1, 16'($urandom), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'b1);
      chk("count_wrap", 32'(xfer_count), 32'd1);
      idle(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
